// File: rtl/uart_agent_core.sv
// uart_agent_core: UART transceiver, 16x oversampled RX,
// show-ahead RX FIFO with per-byte flags, sticky status, frame counters.
`timescale 1ns/1ps
module uart_agent_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int DIV_W      = 16,
  parameter int TMO_W      = 20
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_stop2,
  input  logic             cfg_parity_en,
  input  logic             cfg_even_par,
  input  logic [DIV_W-1:0] cfg_divisor,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             txd,
  input  logic             rxd,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_par_err,
  output logic             rx_frm_err,
  input  logic             rx_ready,
  output logic             rx_overflow,
  output logic             rx_timeout,
  input  logic             err_clr,
  output logic [15:0]      tx_count,
  output logic [15:0]      rx_count
);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP1, R_STOP2
  } rx_state_t;

  // ---------------- TX ----------------
  tx_state_t        tx_state;
  tx_state_t        tx_state_nx;
  logic [DIV_W-1:0] tx_psc;
  logic [DIV_W-1:0] tx_div;
  logic [3:0]       tx_tck;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;
  logic [1:0]       tx_nb;
  logic             tx_s2;
  logic             tx_pe;
  logic             tx_par;
  logic [7:0]       tx_mask;
  logic             tx_bit_end;
  logic             tx_last;
  logic             tx_acc;

  assign tx_mask    = 8'hFF >> (2'd3 - cfg_data_bits);
  assign tx_bit_end = (tx_state != T_IDLE) &&
                      (tx_psc == tx_div) && (tx_tck == 4'd15);
  assign tx_last    = tx_bit_end &&
                      ((tx_state == T_STOP1 && !tx_s2) ||
                       tx_state == T_STOP2);
  // Ready in the final stop cycle too, so the next start bit
  // follows the stop bit with no idle gap.
  assign tx_ready   = (tx_state == T_IDLE) || tx_last;
  assign tx_acc     = tx_valid && tx_ready;

  // TX state register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) tx_state <= T_IDLE;
    else          tx_state <= tx_state_nx;
  end

  // TX next state and serial output
  always_comb begin
    tx_state_nx = tx_state;
    txd         = 1'b1;
    unique case (tx_state)
      T_IDLE: begin
        if (tx_valid) tx_state_nx = T_START;
      end
      T_START: begin
        txd = 1'b0;
        if (tx_bit_end) tx_state_nx = T_DATA;
      end
      T_DATA: begin
        txd = tx_sh[0];
        if (tx_bit_end && tx_bit == {1'b1, tx_nb})
          tx_state_nx = tx_pe ? T_PAR : T_STOP1;
      end
      T_PAR: begin
        txd = tx_par;
        if (tx_bit_end) tx_state_nx = T_STOP1;
      end
      T_STOP1: begin
        if (tx_bit_end) begin
          if (tx_s2)         tx_state_nx = T_STOP2;
          else if (tx_valid) tx_state_nx = T_START;
          else               tx_state_nx = T_IDLE;
        end
      end
      T_STOP2: begin
        if (tx_bit_end)
          tx_state_nx = tx_valid ? T_START : T_IDLE;
      end
      default: tx_state_nx = T_IDLE;
    endcase
  end

  // TX datapath: frame config latch, prescaler, shifter, counter
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_psc   <= '0;
      tx_div   <= '0;
      tx_tck   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_nb    <= '0;
      tx_s2    <= 1'b0;
      tx_pe    <= 1'b0;
      tx_par   <= 1'b0;
      tx_count <= '0;
    end else begin
      if (tx_acc) begin
        tx_psc <= '0;
        tx_div <= cfg_divisor;
        tx_tck <= '0;
        tx_bit <= '0;
        tx_sh  <= tx_data;
        tx_nb  <= cfg_data_bits;
        tx_s2  <= cfg_stop2;
        tx_pe  <= cfg_parity_en;
        tx_par <= (^(tx_data & tx_mask)) ^ ~cfg_even_par;
      end else if (tx_state != T_IDLE) begin
        if (tx_psc == tx_div) begin
          tx_psc <= '0;
          tx_tck <= tx_tck + 4'd1;
          if (tx_tck == 4'd15 && tx_state == T_DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
          end
        end else begin
          tx_psc <= tx_psc + 1'b1;
        end
      end
      if (tx_last) tx_count <= tx_count + 16'd1;
    end
  end

  // ---------------- RX ----------------
  rx_state_t        rx_state;
  rx_state_t        rx_state_nx;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [DIV_W-1:0] rx_psc;
  logic [DIV_W-1:0] rx_div;
  logic [3:0]       rx_tck;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic [1:0]       rx_nb;
  logic             rx_s2;
  logic             rx_pe;
  logic             rx_ev;
  logic             rx_frm;
  logic             rx_perr;
  logic             rx_start;
  logic             rx_tick;
  logic             rx_mid_start;
  logic             rx_samp;
  logic             rx_done;
  logic [9:0]       push_word;

  assign rx_start     = (rx_state == R_IDLE) && rx_prev && !rx_sync;
  assign rx_tick      = (rx_psc == rx_div);
  assign rx_mid_start = (rx_state == R_START) && rx_tick &&
                        (rx_tck == 4'd7);
  assign rx_samp      = (rx_state != R_IDLE) &&
                        (rx_state != R_START) &&
                        rx_tick && (rx_tck == 4'd15);
  assign rx_done      = rx_samp &&
                        ((rx_state == R_STOP1 && !rx_s2) ||
                         rx_state == R_STOP2);
  assign push_word    = {rx_frm | ~rx_sync, rx_perr, rx_sh};

  // Two-flop synchroniser plus edge-detect history
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) rx_state <= R_IDLE;
    else          rx_state <= rx_state_nx;
  end

  // RX next state; after the start check every bit is taken mid-bit
  always_comb begin
    rx_state_nx = rx_state;
    unique case (rx_state)
      R_IDLE: begin
        if (rx_start) rx_state_nx = R_START;
      end
      R_START: begin
        if (rx_mid_start)
          rx_state_nx = rx_sync ? R_IDLE : R_DATA;
      end
      R_DATA: begin
        if (rx_samp && rx_bit == {1'b1, rx_nb})
          rx_state_nx = rx_pe ? R_PAR : R_STOP1;
      end
      R_PAR: begin
        if (rx_samp) rx_state_nx = R_STOP1;
      end
      R_STOP1: begin
        if (rx_samp) rx_state_nx = rx_s2 ? R_STOP2 : R_IDLE;
      end
      R_STOP2: begin
        if (rx_samp) rx_state_nx = R_IDLE;
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  // RX datapath: config latch, prescaler, bit capture, error flags
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_psc   <= '0;
      rx_div   <= '0;
      rx_tck   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_nb    <= '0;
      rx_s2    <= 1'b0;
      rx_pe    <= 1'b0;
      rx_ev    <= 1'b0;
      rx_frm   <= 1'b0;
      rx_perr  <= 1'b0;
      rx_count <= '0;
    end else begin
      if (rx_start) begin
        rx_psc  <= '0;
        rx_div  <= cfg_divisor;
        rx_tck  <= '0;
        rx_bit  <= '0;
        rx_sh   <= '0;
        rx_nb   <= cfg_data_bits;
        rx_s2   <= cfg_stop2;
        rx_pe   <= cfg_parity_en;
        rx_ev   <= cfg_even_par;
        rx_frm  <= 1'b0;
        rx_perr <= 1'b0;
      end else if (rx_state != R_IDLE) begin
        if (rx_tick) begin
          rx_psc <= '0;
          rx_tck <= rx_mid_start ? 4'd0 : rx_tck + 4'd1;
        end else begin
          rx_psc <= rx_psc + 1'b1;
        end
        if (rx_samp && rx_state == R_DATA) begin
          rx_sh[rx_bit] <= rx_sync;
          rx_bit        <= rx_bit + 3'd1;
        end
        if (rx_samp && rx_state == R_PAR)
          rx_perr <= rx_sync ^ (^rx_sh) ^ ~rx_ev;
        if (rx_samp && rx_state == R_STOP1 && !rx_sync)
          rx_frm <= 1'b1;
      end
      if (rx_done) rx_count <= rx_count + 16'd1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [9:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wp;
  logic [FIFO_AW-1:0] rp;
  logic [FIFO_AW:0]   cnt;
  logic             full;
  logic             pop;
  logic             wr;
  logic             ovf_ev;
  logic [9:0]       head;

  assign full     = (cnt == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign wr       = rx_done && (!full || pop);
  assign ovf_ev   = rx_done && full && !pop;
  assign rx_valid = (cnt != '0);
  assign head     = mem[rp];
  assign rx_data    = rx_valid ? head[7:0] : 8'h00;
  assign rx_par_err = rx_valid & head[8];
  assign rx_frm_err = rx_valid & head[9];

  // FIFO storage, written only on an accepted push
  always_ff @(posedge mclk) begin
    if (wr) mem[wp] <= push_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- Status ----------------
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (cfg_timeout != '0) && (tmo_cnt == cfg_timeout);

  // Idle-time counter, saturating, and sticky status flags
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      rx_overflow <= 1'b0;
      rx_timeout  <= 1'b0;
    end else begin
      if (rx_start || err_clr)
        tmo_cnt <= '0;
      else if (rx_state == R_IDLE && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (ovf_ev)       rx_overflow <= 1'b1;
      else if (err_clr) rx_overflow <= 1'b0;
      if (tmo_hit)      rx_timeout  <= 1'b1;
      else if (err_clr) rx_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_agent_core.sv
// tb_uart_agent_core: randomized loopback and directed RX stimulus,
// scoreboard of expected RX FIFO entries checked by a monitor.
`timescale 1ns/1ps
module tb_uart_agent_core;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  cfg_data_bits;
  logic        cfg_stop2, cfg_parity_en, cfg_even_par;
  logic [15:0] cfg_divisor;
  logic [19:0] cfg_timeout;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, txd;
  logic        rxd, rxd_drv, loop;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_par_err, rx_frm_err, rx_ready;
  logic        rx_overflow, rx_timeout, err_clr;
  logic [15:0] tx_count, rx_count;

  int checks = 0;
  int passes = 0;
  int exp_tx = 0;
  int exp_rx = 0;
  logic [9:0] sb[$];
  bit exp_bits[$];

  always #5 mclk = ~mclk;
  assign rxd = loop ? txd : rxd_drv;

  uart_agent_core dut (
    .mclk(mclk), .reset_n(reset_n),
    .cfg_data_bits(cfg_data_bits), .cfg_stop2(cfg_stop2),
    .cfg_parity_en(cfg_parity_en), .cfg_even_par(cfg_even_par),
    .cfg_divisor(cfg_divisor), .cfg_timeout(cfg_timeout),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .txd(txd), .rxd(rxd),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err),
    .rx_ready(rx_ready), .rx_overflow(rx_overflow),
    .rx_timeout(rx_timeout), .err_clr(err_clr),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Expected FIFO entry {frm_err, par_err, data} from the frame rules
  function automatic logic [9:0] model(input logic [7:0] d,
      input int nb, input bit pe, input bit tx_even,
      input bit rx_even, input bit stop_ok);
    int v, ones, p;
    bit perr;
    logic [7:0] m;
    v = int'(d) % (1 << nb);
    m = 8'(v);
    ones = $countones(m);
    p = tx_even ? (ones % 2) : (1 - ones % 2);
    perr = pe && (((ones + p) % 2) != (rx_even ? 0 : 1));
    return {~stop_ok, perr, m};
  endfunction

  task automatic set_cfg(input int nb, input bit s2, input bit pe,
                         input bit ev, input int div);
    cfg_data_bits = 2'(nb - 5);
    cfg_stop2     = s2;
    cfg_parity_en = pe;
    cfg_even_par  = ev;
    cfg_divisor   = 16'(div);
  endtask

  // Called just after a negedge; returns just after the next negedge
  task automatic offer(input logic [7:0] b, output time t);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge mclk);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      $display("FAIL tx_accept: got ready=0 want ready=1 in 5000 cycles");
    end
    @(posedge mclk);
    t = $time;
    exp_tx++;
    @(negedge mclk);
  endtask

  task automatic wait_rx(input logic [15:0] rc, output int n);
    n = 0;
    while (rx_count == rc && n < 20000) begin
      @(posedge mclk);
      n++;
      @(negedge mclk);
    end
    if (rx_count == rc) begin
      checks++;
      $display("FAIL rx_frame_wait: got count=%0h want change", rx_count);
    end
  endtask

  task automatic drive_bit(input bit v, input int div);
    rxd_drv = v;
    repeat (16 * (div + 1)) @(negedge mclk);
  endtask

  // Monitor: compare the FIFO head with the scoreboard on every pop
  always @(negedge mclk) begin : mon
    logic [9:0] e;
    #2;
    if (reset_n && rx_valid && rx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL rx_unexpected: got data=%h want none", rx_data);
      end else begin
        e = sb.pop_front();
        if ({rx_frm_err, rx_par_err, rx_data} === e) passes++;
        else $display("FAIL rx_byte: got f=%b p=%b d=%h want f=%b p=%b d=%h",
                      rx_frm_err, rx_par_err, rx_data, e[9], e[8], e[7:0]);
      end
    end
  end

  initial begin : watchdog
    #900us;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    time t1, t2, t3;
    int d, n, pv, b55;
    logic [15:0] rc;
    logic [7:0] b, first;

    set_cfg(8, 0, 0, 1, 3);
    cfg_timeout = 20'd1000;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rxd_drv  = 1'b1;
    loop     = 1'b0;
    rx_ready = 1'b1;
    err_clr  = 1'b0;
    repeat (3) @(negedge mclk);
    chk("rst_txd", txd, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_flags", {rx_par_err, rx_frm_err, rx_overflow, rx_timeout}, 0);
    chk("rst_counts", {tx_count, rx_count}, 0);

    // Idle timeout at 1000 cycles after reset release
    reset_n = 1'b1;
    repeat (995) @(negedge mclk);
    chk("tmo_before", rx_timeout, 0);
    repeat (10) @(negedge mclk);
    chk("tmo_after", rx_timeout, 1);
    cfg_timeout = 20'd0;
    err_clr = 1'b1;
    @(negedge mclk);
    err_clr = 1'b0;
    chk("tmo_clear", rx_timeout, 0);

    // Loopback 8N1, divisor 3, back-to-back
    loop = 1'b1;
    sb.push_back(model(8'hA5, 8, 0, 1, 1, 1));
    sb.push_back(model(8'h3C, 8, 0, 1, 1, 1));
    offer(8'hA5, t1);
    offer(8'h3C, t2);
    tx_valid = 1'b0;
    exp_rx += 2;
    chk("frame_period", 32'(t2 - t1), 6400);
    repeat (700) @(negedge mclk);
    chk("b2b_tx_count", tx_count, 16'(exp_tx));
    chk("b2b_rx_count", rx_count, 16'(exp_rx));

    // 7E2 stream check on txd
    set_cfg(7, 1, 1, 1, 3);
    b55 = 'h55;
    exp_bits.push_back(0);
    for (int i = 0; i < 7; i++) exp_bits.push_back(((b55 >> i) & 1) != 0);
    pv = $countones(b55 & 'h7F) % 2;
    exp_bits.push_back(pv != 0);
    exp_bits.push_back(1);
    exp_bits.push_back(1);
    sb.push_back(model(8'h55, 7, 1, 1, 1, 1));
    offer(8'h55, t1);
    tx_valid = 1'b0;
    #318;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("txd_7e2_bit%0d", k), txd, exp_bits[k]);
      #640;
    end
    @(negedge mclk);
    exp_rx++;

    // Same frame, RX parity sense flipped after TX latched its config
    sb.push_back(model(8'h55, 7, 1, 1, 0, 1));
    rc = rx_count;
    offer(8'h55, t1);
    cfg_even_par = 1'b0;
    tx_valid = 1'b0;
    wait_rx(rc, n);
    exp_rx++;
    cfg_even_par = 1'b1;
    repeat (400) @(negedge mclk);

    // Zero stop bit driven directly
    loop = 1'b0;
    rxd_drv = 1'b1;
    set_cfg(8, 0, 0, 1, 3);
    @(negedge mclk);
    sb.push_back(model(8'h96, 8, 0, 1, 1, 0));
    drive_bit(0, 3);
    for (int i = 0; i < 8; i++) drive_bit(((8'h96 >> i) & 8'h01) != 0, 3);
    drive_bit(0, 3);
    drive_bit(1, 3);
    drive_bit(1, 3);
    exp_rx++;
    chk("frm_rx_count", rx_count, 16'(exp_rx));

    // One-tick low glitch: false start
    rxd_drv = 1'b0;
    repeat (4) @(negedge mclk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge mclk);
    chk("glitch_rx_count", rx_count, 16'(exp_rx));
    chk("glitch_no_push", rx_valid, 0);

    // FIFO fill, overflow, simultaneous push/pop when full
    loop = 1'b1;
    rx_ready = 1'b0;
    set_cfg(8, 0, 0, 1, 0);
    d = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      sb.push_back(model(b, 8, 0, 1, 1, 1));
      rc = rx_count;
      offer(b, t1);
      tx_valid = 1'b0;
      wait_rx(rc, n);
      exp_rx++;
      if (i == 0) d = n;
    end
    chk("full_valid", rx_valid, 1);
    chk("full_no_ovf", rx_overflow, 0);
    first = sb[0][7:0];
    rc = rx_count;
    offer(8'($urandom), t1);
    tx_valid = 1'b0;
    wait_rx(rc, n);
    exp_rx++;
    chk("ovf_set", rx_overflow, 1);
    chk("ovf_head", rx_data, first);
    chk("ovf_rx_count", rx_count, 16'(exp_rx));
    err_clr = 1'b1;
    @(negedge mclk);
    err_clr = 1'b0;
    chk("ovf_clear", rx_overflow, 0);
    b = 8'($urandom);
    sb.push_back(model(b, 8, 0, 1, 1, 1));
    rc = rx_count;
    offer(b, t3);
    tx_valid = 1'b0;
    repeat (d - 1) @(negedge mclk);
    rx_ready = 1'b1;
    @(negedge mclk);
    rx_ready = 1'b0;
    exp_rx++;
    chk("pushpop_count", rx_count, 16'(exp_rx));
    chk("pushpop_no_ovf", rx_overflow, 0);
    rx_ready = 1'b1;
    repeat (40) @(negedge mclk);
    chk("drain_empty", {31'd0, rx_valid}, 0);
    chk("drain_sb", sb.size(), 0);

    // Randomized loopback frames with random formats
    for (int i = 0; i < 20; i++) begin
      int nb, dv;
      bit s2, pe, ev;
      nb = int'($urandom_range(5, 8));
      s2 = 1'($urandom);
      pe = 1'($urandom);
      ev = 1'($urandom);
      dv = int'($urandom_range(0, 3));
      set_cfg(nb, s2, pe, ev, dv);
      b = 8'($urandom);
      sb.push_back(model(b, nb, pe, ev, ev, 1));
      rc = rx_count;
      offer(b, t1);
      tx_valid = 1'b0;
      wait_rx(rc, n);
      exp_rx++;
    end
    repeat (800) @(negedge mclk);
    chk("final_tx_count", tx_count, 16'(exp_tx));
    chk("final_rx_count", rx_count, 16'(exp_rx));
    chk("final_sb", sb.size(), 0);

    // Reset in the middle of a TX frame
    set_cfg(8, 0, 0, 1, 3);
    offer(8'h00, t1);
    tx_valid = 1'b0;
    repeat (100) @(negedge mclk);
    chk("mid_txd_low", txd, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_counts", {tx_count, rx_count}, 0);
    chk("arst_rx_valid", rx_valid, 0);
    repeat (3) @(negedge mclk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
